multicycle_cpu_param: RTL and testbench

Parametrised successor to the 8-bit/5-bit multi-cycle accumulator processor: same accumulator ISA, generalised data and address widths. Adds a request/ready memory handshake that tolerates wait states, plus an optional halt detector. Top of the processor subsystem; connects to one shared instruction/data memory.

---
 rtl/mcp_pkg.sv | 26 ++
 rtl/mcp_alu.sv | 28 ++
 rtl/multicycle_cpu_param.sv | 122 ++++++++++++
 tb/tb_multicycle_cpu_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared types for the parametrised multi-cycle accumulator processor:
// opcode encoding, FSM states and opcode field width.
package mcp_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_NOT = 3'b101,
    OP_JMP = 3'b110,
    OP_JZ  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWR,
    S_HALT
  } state_e;

endpackage

// File: rtl/mcp_alu.sv
// Combinational accumulator ALU: LDA pass-through, ADD, SUB, AND, NOT.
// Arithmetic wraps modulo 2^DATA_W; no flags are produced.
module mcp_alu
  import mcp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  op_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] result_o
);

  // NOTE: the default assignment before the case keeps every path driven,
  // so no latch is inferred for opcodes that leave the accumulator alone.
  always_comb begin
    result_o = acc_i;
    case (opcode_e'(op_i))
      OP_LDA:  result_o = operand_i;
      OP_ADD:  result_o = acc_i + operand_i;
      OP_SUB:  result_o = acc_i - operand_i;
      OP_AND:  result_o = acc_i & operand_i;
      OP_NOT:  result_o = ~acc_i;
      default: result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu_param.sv
// Multi-cycle accumulator processor with a request/ready memory handshake.
// Optional halt detector on a self-jump, enabled by defining MCP_HALT_EN.
module multicycle_cpu_param
  import mcp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  opcode_e             ir_op_q, ir_op_d;
  logic [ADDR_W-1:0]   ir_addr_q, ir_addr_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   alu_result;

  mcp_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (ir_op_q),
    .acc_i     (acc_q),
    .operand_i (mem_rdata),
    .result_o  (alu_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      acc_q     <= '0;
      ir_op_q   <= OP_LDA;
      ir_addr_q <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ir_op_q   <= ir_op_d;
      ir_addr_q <= ir_addr_d;
      mem_req_q <= mem_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_op_d   = ir_op_q;
    ir_addr_d = ir_addr_q;

    case (state_q)
      // A fetch only completes once the registered request is actually out.
      S_FETCH: begin
        if (mem_req_q && mem_ready) begin
          ir_op_d   = opcode_e'(mem_rdata[DATA_W-1 -: OPC_W]);
          ir_addr_d = mem_rdata[ADDR_W-1:0];
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_FETCH;
        case (ir_op_q)
          OP_NOT: acc_d = alu_result;
          OP_JMP: begin
            pc_d = ir_addr_q;
`ifdef MCP_HALT_EN
            if (ir_addr_q == pc_q) state_d = S_HALT;
`endif
          end
          OP_JZ:   if (acc_q == '0) pc_d = ir_addr_q;
          OP_STA:  state_d = S_MEMWR;
          default: state_d = S_MEMRD;
        endcase
      end
      S_MEMRD: begin
        if (mem_ready) begin
          acc_d   = alu_result;
          state_d = S_FETCH;
        end
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
      end
`ifdef MCP_HALT_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase

    mem_req_d = (state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR);
  end

  // Address, direction and write data derive from registered state only,
  // so they hold steady across wait states.
  assign mem_req   = mem_req_q;
  assign mem_we    = (state_q == S_MEMWR);
  assign mem_addr  = (state_q == S_FETCH) ? pc_q : ir_addr_q;
  assign mem_wdata = acc_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;

`ifdef MCP_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_cpu_param.sv
// Directed bench for multicycle_cpu_param: memory model with configurable
// wait states, hand-computed expectations for a short accumulator program.
module tb_multicycle_cpu_param;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ready, halted;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata, mem_rdata, acc_out;

  logic [DW-1:0] mem [32];
  int            nwait, wcnt, cyc;
  int            n_cmp, n_bad;
  int            wr_cyc, unstable;
  logic          wr_seen;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          prev_wait, prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  multicycle_cpu_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_ready = mem_req && (wcnt == nwait);
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: model memory before the edge, then settle 1 time unit after it.
  task automatic tick();
    logic rdy;
    int   nxt;
    rdy = mem_req && (wcnt == nwait);
    if (prev_wait && mem_req &&
        (mem_addr != prev_addr || mem_we != prev_we || (mem_we && mem_wdata != prev_wdata)))
      unstable++;
    prev_wait  = mem_req && !rdy;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
    if (rdy && mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_seen = 1'b1;
      wr_cyc  = cyc;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
    end
    nxt = (!mem_req || rdy) ? 0 : wcnt + 1;
    @(posedge clk);
    #1;
    wcnt = nxt;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset(input int w);
    rst       = 1'b1;
    nwait     = w;
    wcnt      = 0;
    prev_wait = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    cyc       = 0;
    wr_seen   = 1'b0;
    unstable  = 0;
  endtask

  task automatic wait_write(input int budget);
    int n;
    n = 0;
    while (!wr_seen && n < budget) begin
      tick();
      n++;
    end
    check("write_seen", wr_seen, 1);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0]    = 8'h0A;  // LDA 10
    mem[1]    = 8'h4B;  // ADD 11
    mem[2]    = 8'h2C;  // STA 12
    mem[3]    = 8'h6D;  // SUB 13
    mem[4]    = 8'hFF;  // JZ 0x1F (not taken)
    mem[5]    = 8'hA0;  // NOT
    mem[6]    = 8'hF5;  // JZ 0x15 (taken)
    mem[10]   = 8'h05;
    mem[11]   = 8'hFD;
    mem[13]   = 8'h03;
    mem[14]   = 8'h3C;
    mem[15]   = 8'h0F;
    mem[5'h15] = 8'h0E; // LDA 14
    mem[5'h16] = 8'h8F; // AND 15
    mem[5'h17] = 8'hDF; // JMP 0x1F
    mem[5'h1F] = 8'hDF; // JMP 0x1F (self)
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad_hold;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    wcnt  = 0;
    nwait = 0;
    prev_wait = 1'b0;
    load_prog();
    @(posedge clk);
    #1;

    // Zero wait states: full program walk.
    do_reset(0);
    check("rst_req", mem_req, 0);
    check("rst_pc", pc_out, 0);
    check("rst_acc", acc_out, 0);
    check("rst_halted", halted, 0);
    tick();
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    check("first_we", mem_we, 0);
    run_to(4);
    check("lda_acc", acc_out, 8'h05);
    run_to(7);
    check("add_acc", acc_out, 8'h02);
    check("fetch2_addr", mem_addr, 2);
    wait_write(20);
    check("sta_cycle", wr_cyc, 9);
    check("sta_addr", wr_addr, 12);
    check("sta_data", wr_data, 8'h02);
    run_to(13);
    check("sub_acc", acc_out, 8'hFF);
    run_to(15);
    check("jz_nt_pc", pc_out, 5);
    check("jz_nt_addr", mem_addr, 5);
    run_to(17);
    check("not_acc", acc_out, 8'h00);
    run_to(19);
    check("jz_t_pc", pc_out, 5'h15);
    check("jz_t_addr", mem_addr, 5'h15);
    run_to(22);
    check("lda2_acc", acc_out, 8'h3C);
    run_to(25);
    check("and_acc", acc_out, 8'h0C);
    check("fetch17_addr", mem_addr, 5'h17);
    run_to(27);
    check("jmp_pc", pc_out, 5'h1F);
    check("jmp_addr", mem_addr, 5'h1F);
    run_to(29);
`ifdef MCP_HALT_EN
    check("halt_flag", halted, 1);
    check("halt_req", mem_req, 0);
    bad_hold = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req !== 1'b0 || halted !== 1'b1 || pc_out !== 5'h1F) bad_hold++;
    end
    check("halt_hold", bad_hold, 0);
`else
    check("self_jmp_halted", halted, 0);
    check("self_jmp_req", mem_req, 1);
    check("self_jmp_addr", mem_addr, 5'h1F);
    run_to(31);
    check("self_jmp_again_req", mem_req, 1);
    check("self_jmp_again_addr", mem_addr, 5'h1F);
`endif

    // Three wait states per access: six accesses before the write lands.
    load_prog();
    do_reset(3);
    wait_write(100);
    check("ws_sta_cycle", wr_cyc, 27);
    check("ws_sta_addr", wr_addr, 12);
    check("ws_sta_data", wr_data, 8'h02);
    check("ws_stable", unstable, 0);

    // Reset during a stalled MEMRD.
    load_prog();
    do_reset(0);
    run_to(3);
    check("memrd_req", mem_req, 1);
    check("memrd_addr", mem_addr, 10);
    nwait = 100;
    tick();
    tick();
    check("stall_req", mem_req, 1);
    check("stall_addr", mem_addr, 10);
    check("stall_pc", pc_out, 1);
    rst = 1'b1;
    tick();
    check("abort_req", mem_req, 0);
    check("abort_pc", pc_out, 0);
    check("abort_acc", acc_out, 0);
    rst   = 1'b0;
    nwait = 0;
    wcnt  = 0;
    cyc   = 0;
    tick();
    check("resume_req", mem_req, 1);
    check("resume_addr", mem_addr, 0);
    run_to(4);
    check("resume_acc", acc_out, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
